rgb_pwm_gen: RTL and testbench

Three-channel PWM generator that produces the red, green and blue PWM drive signals for the on-chip RGB LED driver's RGB0PWM/RGB1PWM/RGB2PWM inputs. It replaces constant-on PWM inputs with programmable per-channel duty cycles. New colours arrive over a valid/ready handshake and are double-buffered, so they only take effect at a PWM period boundary and never cause glitches. It sits between colour-producing logic (sequencers, UART command decoders) and the LED driver primitive.

---
 rtl/rgb_pwm_gen_if.sv | 18 +
 rtl/rgb_pwm_gen.sv | 126 ++++++++++++
 tb/tb_rgb_pwm_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_gen_if.sv
// ---------------------------------------------------------------------------
// rgb_pwm_gen_if
// Colour-word handshake between a colour producer and rgb_pwm_gen.
//   color_valid : producer offers a colour word
//   color_ready : consumer can accept a colour word
//   color_rgb   : {red, green, blue} duty values, red in the MSBs
// Modports: master = colour producer, slave = rgb_pwm_gen.
// ---------------------------------------------------------------------------
interface rgb_pwm_gen_if #(
    parameter int PWM_BITS = 8
) ();
    logic                    color_valid;
    logic                    color_ready;
    logic [3*PWM_BITS-1:0]   color_rgb;

    modport master (output color_valid, output color_rgb, input  color_ready);
    modport slave  (input  color_valid, input  color_rgb, output color_ready);
endinterface

// File: rtl/rgb_pwm_gen.sv
// ---------------------------------------------------------------------------
// rgb_pwm_gen
// Three-channel PWM generator feeding the RGB LED driver PWM inputs.
// Colour words are double-buffered: an accepted word waits in a pending
// register and is copied to the active duty only at a period wrap (or at
// once while disabled), so a colour change never truncates a period.
//
// Parameters
//   CLK_DIV  : prescaler terminal count; phase advances every CLK_DIV+1 clocks
//   PWM_BITS : duty/phase width; period is 2^PWM_BITS ticks
// Ports
//   hw_clk       : sole clock
//   reset_n      : asynchronous active-low reset
//   enable       : run PWM when high; outputs low and counters held at 0 when low
//   color        : colour handshake (slave side)
//   pwm_red/green/blue : registered PWM drive to RGB0PWM/RGB1PWM/RGB2PWM
//   period_start : one-clock pulse in the first clock of each period
// ---------------------------------------------------------------------------
module rgb_pwm_gen #(
    parameter int CLK_DIV  = 47,
    parameter int PWM_BITS = 8
) (
    input  logic           hw_clk,
    input  logic           reset_n,
    input  logic           enable,
    rgb_pwm_gen_if.slave   color,
    output logic           pwm_red,
    output logic           pwm_green,
    output logic           pwm_blue,
    output logic           period_start
);

    localparam int PS_W  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int RGB_W = 3 * PWM_BITS;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV);

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] phase_q,     phase_d;
    logic [RGB_W-1:0]    active_q,    active_d;
    logic [RGB_W-1:0]    pend_data_q, pend_data_d;
    logic                pend_q,      pend_d;
    logic [2:0]          pwm_q,       pwm_d;      // {red, green, blue}
    logic                period_start_q, period_start_d;

    logic tick;
    logic wrap;
    logic xfer;
    logic commit;

    // Ready depends only on the pending flag, never on color_valid.
    assign color.color_ready = ~pend_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through this block leaves one unassigned (which would infer a latch).
        prescaler_d    = prescaler_q;
        phase_d        = phase_q;
        active_d       = active_q;
        pend_data_d    = pend_data_q;
        pend_d         = pend_q;
        pwm_d          = '0;
        period_start_d = 1'b0;

        tick = (prescaler_q == PS_MAX);
        wrap = tick && (&phase_q);
        xfer = color.color_valid && !pend_q;
        // While disabled there is no period to protect, so commit at once.
        commit = pend_q && (wrap || !enable);

        if (!enable) begin
            prescaler_d = '0;
            phase_d     = '0;
        end else if (tick) begin
            prescaler_d = '0;
            phase_d     = phase_q + PWM_BITS'(1);   // wraps naturally at all-ones
        end else begin
            prescaler_d = prescaler_q + PS_W'(1);
        end

        // commit and xfer are mutually exclusive: xfer needs pend_q low.
        if (commit) begin
            active_d = pend_data_q;
            pend_d   = 1'b0;
        end else if (xfer) begin
            pend_data_d = color.color_rgb;
            pend_d      = 1'b1;
        end

        // Compare against the duty in use this clock; output lags by one clock.
        pwm_d[2] = enable && (phase_q < active_q[RGB_W-1 -: PWM_BITS]);
        pwm_d[1] = enable && (phase_q < active_q[2*PWM_BITS-1 -: PWM_BITS]);
        pwm_d[0] = enable && (phase_q < active_q[PWM_BITS-1:0]);

        period_start_d = enable && wrap;
    end

    // NOTE: all state, including the duty registers, is cleared by reset so a
    // word pending when reset hits is discarded and outputs come up low.
    always_ff @(posedge hw_clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q    <= '0;
            phase_q        <= '0;
            active_q       <= '0;
            pend_data_q    <= '0;
            pend_q         <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            prescaler_q    <= prescaler_d;
            phase_q        <= phase_d;
            active_q       <= active_d;
            pend_data_q    <= pend_data_d;
            pend_q         <= pend_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_red      = pwm_q[2];
    assign pwm_green    = pwm_q[1];
    assign pwm_blue     = pwm_q[0];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_gen
// Two instances: dut0 with CLK_DIV = 0 (256-clock period) and dut2 with
// CLK_DIV = 2 (768-clock period). Per-instance monitors accumulate PWM
// high-time between period_start pulses; a window runs from the clock after
// one period_start through the next one, which matches the one-clock lag of
// the PWM outputs behind the phase counter.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_gen;

    logic hw_clk;
    logic reset_n;
    logic en0, en2;
    logic red0, green0, blue0, ps0;
    logic red2, green2, blue2, ps2;

    rgb_pwm_gen_if #(.PWM_BITS(8)) c0 ();
    rgb_pwm_gen_if #(.PWM_BITS(8)) c2 ();

    rgb_pwm_gen #(.CLK_DIV(0), .PWM_BITS(8)) dut0 (
        .hw_clk(hw_clk), .reset_n(reset_n), .enable(en0), .color(c0.slave),
        .pwm_red(red0), .pwm_green(green0), .pwm_blue(blue0), .period_start(ps0)
    );

    rgb_pwm_gen #(.CLK_DIV(2), .PWM_BITS(8)) dut2 (
        .hw_clk(hw_clk), .reset_n(reset_n), .enable(en2), .color(c2.slave),
        .pwm_red(red2), .pwm_green(green2), .pwm_blue(blue2), .period_start(ps2)
    );

    initial hw_clk = 1'b0;
    always #5 hw_clk = ~hw_clk;

    int n_vec = 0;
    int n_mis = 0;

    // Window monitors.
    int acc0_r = 0, acc0_g = 0, acc0_b = 0, len0 = 0;
    int win0_r = 0, win0_g = 0, win0_b = 0, win0_len = 0, win0_id = 0;
    int acc2_r = 0, len2 = 0;
    int win2_r = 0, win2_len = 0, win2_id = 0;

    always @(negedge hw_clk) begin
        acc0_r += int'(red0); acc0_g += int'(green0); acc0_b += int'(blue0); len0++;
        if (ps0) begin
            win0_r = acc0_r; win0_g = acc0_g; win0_b = acc0_b; win0_len = len0;
            acc0_r = 0; acc0_g = 0; acc0_b = 0; len0 = 0;
            win0_id++;
        end
        acc2_r += int'(red2); len2++;
        if (ps2) begin
            win2_r = acc2_r; win2_len = len2;
            acc2_r = 0; len2 = 0;
            win2_id++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge (after the monitors ran).
    task automatic step();
        @(negedge hw_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a word, wait (bounded) for ready, hold valid through the transfer edge.
    task automatic tx(input int sel, input logic [23:0] word);
        int n = 0;
        while (((sel == 0) ? !c0.color_ready : !c2.color_ready) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) check("tx_ready_timeout", 0, 1);
        if (sel == 0) begin c0.color_valid = 1'b1; c0.color_rgb = word; end
        else          begin c2.color_valid = 1'b1; c2.color_rgb = word; end
        step();
        c0.color_valid = 1'b0;
        c2.color_valid = 1'b0;
    endtask

    task automatic wait_win0(input int target);
        int n = 0;
        while (win0_id < target && n < 2000) begin step(); n++; end
        if (n >= 2000) check("win0_timeout", win0_id, target);
    endtask

    task automatic wait_ready0();
        int n = 0;
        while (!c0.color_ready && n < 2000) begin step(); n++; end
        if (n >= 2000) check("ready0_timeout", 0, 1);
    endtask

    typedef struct {
        logic [23:0] rgb;
        int          r;
        int          g;
        int          b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int w;
        int hi;
        int n;

        vecs[0] = '{24'h4080FF, 64,  128, 255};
        vecs[1] = '{24'h0001FE, 0,   1,   254};
        vecs[2] = '{24'h10C07F, 16,  192, 127};
        vecs[3] = '{24'h8000FF, 128, 0,   255};

        reset_n = 1'b0;
        en0 = 1'b0;
        en2 = 1'b0;
        c0.color_valid = 1'b0; c0.color_rgb = '0;
        c2.color_valid = 1'b0; c2.color_rgb = '0;

        // ---- Reset values ----
        steps(2);
        check("rst_red",   int'(red0),   0);
        check("rst_ps",    int'(ps0),    0);
        check("rst_ready", int'(c0.color_ready), 1);
        reset_n = 1'b1;
        en0 = 1'b1;
        step();

        // ---- Reset mid-period with a pending word ----
        tx(0, 24'hFFFFFF);
        check("pend_ready_low", int'(c0.color_ready), 0);
        steps(50);
        reset_n = 1'b0;
        #2;
        check("arst_ready", int'(c0.color_ready), 1);
        check("arst_pwm",   int'(red0 | green0 | blue0), 0);
        check("arst_ps",    int'(ps0), 0);
        step();
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            hi += int'(red0 | green0 | blue0);
        end
        check("post_rst_pwm_high", hi, 0);

        // ---- Duty accuracy, table driven ----
        for (int v = 0; v < 4; v++) begin
            tx(0, vecs[v].rgb);
            wait_ready0();
            check($sformatf("v%0d_commit_on_wrap", v), int'(ps0), 1);
            w = win0_id;
            wait_win0(w + 1);
            check($sformatf("v%0d_red", v),   win0_r,   vecs[v].r);
            check($sformatf("v%0d_green", v), win0_g,   vecs[v].g);
            check($sformatf("v%0d_blue", v),  win0_b,   vecs[v].b);
            check($sformatf("v%0d_len", v),   win0_len, 256);
        end

        // ---- Glitch-free update: red 0x80 -> 0x10 mid-period ----
        w = win0_id;
        steps(20);
        tx(0, 24'h1000FF);
        check("glitch_ready_low", int'(c0.color_ready), 0);
        wait_win0(w + 1);
        check("glitch_cur_red", win0_r, 128);
        check("glitch_ready_back", int'(c0.color_ready), 1);
        wait_win0(w + 2);
        check("glitch_next_red", win0_r, 16);

        // ---- Back-pressure: two words back to back ----
        tx(0, 24'h200000);
        tx(0, 24'h300000);
        w = win0_id;
        wait_win0(w + 1);
        check("bp_first_red", win0_r, 32);
        wait_win0(w + 2);
        check("bp_second_red", win0_r, 48);

        // ---- Transfer on the wrap-event clock ----
        w = win0_id;       // currently in the period_start cycle of a period
        steps(255);
        c0.color_valid = 1'b1;
        c0.color_rgb   = 24'h080000;
        step();
        c0.color_valid = 1'b0;
        check("wrapx_ps", int'(ps0), 1);
        check("wrapx_ready_low", int'(c0.color_ready), 0);
        wait_win0(w + 2);
        check("wrapx_old_red", win0_r, 48);
        wait_win0(w + 3);
        check("wrapx_new_red", win0_r, 8);

        // ---- Enable gating and prescaler (CLK_DIV = 2) ----
        tx(2, 24'h010000);
        check("dis_ready_low", int'(c2.color_ready), 0);
        check("dis_pwm", int'(red2 | green2 | blue2), 0);
        step();
        check("dis_ready_back", int'(c2.color_ready), 1);
        check("dis_ps", int'(ps2), 0);
        en2 = 1'b1;
        hi = 0;
        n = 0;
        do begin
            step();
            n++;
            hi += int'(red2);
        end while (!ps2 && n < 2000);
        check("en_first_period_len", n, 768);
        check("en_first_period_red", hi, 3);
        w = win2_id;
        n = 0;
        while (win2_id < w + 1 && n < 2000) begin step(); n++; end
        check("div2_red", win2_r, 3);
        check("div2_len", win2_len, 768);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
